stream_demux: RTL and testbench

- Registered, handshaked 1-to-N demultiplexer for the relational cache datapath.
- Parametrised successor of the fixed 16-way combinational demux: width and output count are configurable, each output has valid/ready flow control, and a multicast mode delivers one beat to several outputs.
- Sits between the request-decode stage and the per-bank/per-column request queues.

---
 rtl/rc_pkg.sv | 13 +
 rtl/stream_demux_sel_to_mask.sv | 34 +++
 rtl/stream_demux.sv | 85 ++++++++
 tb/tb_stream_demux.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
// Shared definitions for the relational cache routing blocks.
// Default demux geometry and destination mode encoding.
package rc_pkg;

    localparam int DEMUX_DEF_DATA_W = 16;
    localparam int DEMUX_DEF_N_OUT  = 16;

    typedef enum logic {
        DEST_UNICAST   = 1'b0,
        DEST_MULTICAST = 1'b1
    } dest_mode_e;

endpackage

// File: rtl/stream_demux_sel_to_mask.sv
// Destination decoder: unicast index or multicast mask to a target bitmask.
// Out-of-range unicast indices decode to an empty mask.
module sel_to_mask
    import rc_pkg::*;
#(
    parameter int N_OUT = DEMUX_DEF_N_OUT,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_mcast,
    input  logic [N_OUT-1:0] i_mask,
    output logic [N_OUT-1:0] o_tgt
);

    logic [N_OUT-1:0] uni_mask;
    dest_mode_e       mode;

    // Only indices below N_OUT have a decoder bit, so larger selects match nothing.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_onehot
            assign uni_mask[gi] = (i_sel == SEL_W'(gi));
        end
    endgenerate

    assign mode = dest_mode_e'(i_mcast);

    always_comb begin
        o_tgt = uni_mask;
        if (mode == DEST_MULTICAST) begin
            o_tgt = i_mask;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-channel valid/ready,
// multicast delivery and a saturating count of undeliverable beats.
module stream_demux
    import rc_pkg::*;
#(
    parameter int DATA_W = DEMUX_DEF_DATA_W,
    parameter int N_OUT  = DEMUX_DEF_N_OUT,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int CNT_W  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_W-1:0]       i_din,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_mcast,
    input  logic [N_OUT-1:0]        i_mask,
    output logic [N_OUT*DATA_W-1:0] o_dout,
    output logic [N_OUT-1:0]        o_valid,
    input  logic [N_OUT-1:0]        i_ready,
    output logic                    o_drop,
    output logic [CNT_W-1:0]        o_drop_cnt
);

    logic [DATA_W-1:0] data_reg;
    logic [N_OUT-1:0]  pend_reg;
    logic              drop_reg;
    logic [CNT_W-1:0]  drop_cnt_reg;

    logic [N_OUT-1:0]  rem_mask;
    logic [N_OUT-1:0]  tgt_mask;
    logic              accept;

    sel_to_mask #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_sel_to_mask (
        .i_sel   (i_sel),
        .i_mcast (i_mcast),
        .i_mask  (i_mask),
        .o_tgt   (tgt_mask)
    );

    // Ready is combinational from i_ready so a fully drained beat can be
    // replaced in the same cycle its last copy is taken.
    assign rem_mask = pend_reg & ~i_ready;
    assign o_ready  = (rem_mask == '0);
    assign accept   = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_reg     <= '0;
            pend_reg     <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (accept) begin
            if (tgt_mask != '0) begin
                data_reg <= i_din;
                pend_reg <= tgt_mask;
                drop_reg <= 1'b0;
            end else begin
                pend_reg <= '0;
                drop_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                end
            end
        end else begin
            pend_reg <= rem_mask;
            drop_reg <= 1'b0;
        end
    end

    assign o_valid    = pend_reg;
    assign o_drop     = drop_reg;
    assign o_drop_cnt = drop_cnt_reg;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dout
            assign o_dout[gi*DATA_W +: DATA_W] = pend_reg[gi] ? data_reg : '0;
        end
    endgenerate

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 16-way instance for the main flows and a
// 12-way, 2-bit-counter instance for drop handling and counter saturation.
module tb_stream_demux;

    logic clk;
    logic rstn;

    // 16-way instance
    logic         a_valid;
    logic         a_ready;
    logic [15:0]  a_din;
    logic [3:0]   a_sel;
    logic         a_mcast;
    logic [15:0]  a_mask;
    logic [255:0] a_dout;
    logic [15:0]  a_ovalid;
    logic [15:0]  a_iready;
    logic         a_drop;
    logic [7:0]   a_cnt;

    // 12-way instance with a 2-bit drop counter
    logic         b_valid;
    logic         b_ready;
    logic [15:0]  b_din;
    logic [3:0]   b_sel;
    logic         b_mcast;
    logic [11:0]  b_mask;
    logic [191:0] b_dout;
    logic [11:0]  b_ovalid;
    logic [11:0]  b_iready;
    logic         b_drop;
    logic [1:0]   b_cnt;

    int checks;
    int errors;

    stream_demux #(.DATA_W(16), .N_OUT(16), .CNT_W(8)) dut_a (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (a_valid),
        .o_ready    (a_ready),
        .i_din      (a_din),
        .i_sel      (a_sel),
        .i_mcast    (a_mcast),
        .i_mask     (a_mask),
        .o_dout     (a_dout),
        .o_valid    (a_ovalid),
        .i_ready    (a_iready),
        .o_drop     (a_drop),
        .o_drop_cnt (a_cnt)
    );

    stream_demux #(.DATA_W(16), .N_OUT(12), .CNT_W(2)) dut_b (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (b_valid),
        .o_ready    (b_ready),
        .i_din      (b_din),
        .i_sel      (b_sel),
        .i_mcast    (b_mcast),
        .i_mask     (b_mask),
        .o_dout     (b_dout),
        .o_valid    (b_ovalid),
        .i_ready    (b_iready),
        .o_drop     (b_drop),
        .o_drop_cnt (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_valid = 0; a_din = '0; a_sel = '0; a_mcast = 0; a_mask = '0; a_iready = '1;
        b_valid = 0; b_din = '0; b_sel = '0; b_mcast = 0; b_mask = '0; b_iready = '1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_ovalid !== 16'h0000 || a_dout !== '0) begin
            errors++;
            $display("FAIL reset_out: o_valid=%h o_dout_nonzero=%0b, required 0000 and 0", a_ovalid, |a_dout);
        end
        checks++;
        if (a_ready !== 1'b1 || a_drop !== 1'b0 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctl: o_ready=%b o_drop=%b cnt=%0d, required 1 0 0", a_ready, a_drop, a_cnt);
        end
        rstn = 1'b1;
        $display("[tb] reset released");
    endtask

    task automatic test_unicast();
        logic [255:0] others;
        a_valid = 1; a_sel = 4'd5; a_din = 16'hABCD; a_mcast = 0; a_iready = '1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL uni_ready: o_ready=%b, required 1", a_ready);
        end
        step();
        a_valid = 0;
        checks++;
        if (a_ovalid !== 16'h0020) begin
            errors++;
            $display("FAIL uni_valid: o_valid=%h, required 0020", a_ovalid);
        end
        checks++;
        if (a_dout[5*16 +: 16] !== 16'hABCD) begin
            errors++;
            $display("FAIL uni_data: ch5=%h, required abcd", a_dout[5*16 +: 16]);
        end
        others = a_dout;
        others[5*16 +: 16] = '0;
        checks++;
        if (others !== '0) begin
            errors++;
            $display("FAIL uni_others: other channels nonzero=%h", others);
        end
        $display("[tb] unicast sel=5 din=abcd -> o_valid=%h", a_ovalid);
        step();
        checks++;
        if (a_ovalid !== 16'h0000) begin
            errors++;
            $display("FAIL uni_done: o_valid=%h, required 0000", a_ovalid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            a_valid = 1; a_sel = 4'(i); a_din = 16'h1000 + 16'(i); a_mcast = 0; a_iready = '1;
            #1;
            checks++;
            if (a_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: o_ready=%b, required 1", i, a_ready);
            end
            step();
            checks++;
            if (a_ovalid !== (16'h1 << i) || a_dout[i*16 +: 16] !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL b2b_beat[%0d]: o_valid=%h data=%h, required %h %h",
                         i, a_ovalid, a_dout[i*16 +: 16], 16'h1 << i, 16'h1000 + 16'(i));
            end
            $display("[tb] b2b beat %0d o_valid=%h data=%h", i, a_ovalid, a_dout[i*16 +: 16]);
        end
        a_valid = 0;
        step();
        checks++;
        if (a_ovalid !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_drain: o_valid=%h, required 0000", a_ovalid);
        end
    endtask

    task automatic test_backpressure();
        a_iready = 16'hFFF7;
        a_valid = 1; a_sel = 4'd3; a_din = 16'h3333; a_mcast = 0;
        step();
        a_valid = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (a_ovalid !== 16'h0008 || a_dout[3*16 +: 16] !== 16'h3333 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: o_valid=%h ch3=%h o_ready=%b, required 0008 3333 0",
                         c, a_ovalid, a_dout[3*16 +: 16], a_ready);
            end
            $display("[tb] backpressure cycle %0d o_valid=%h", c, a_ovalid);
            step();
        end
        a_iready = 16'hFFFF;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: o_ready=%b, required 1", a_ready);
        end
        step();
        checks++;
        if (a_ovalid !== 16'h0000) begin
            errors++;
            $display("FAIL bp_done: o_valid=%h, required 0000", a_ovalid);
        end
    endtask

    task automatic test_multicast();
        a_iready = 16'h0000;
        a_valid = 1; a_mcast = 1; a_mask = 16'h8101; a_din = 16'h5A5A;
        step();
        a_valid = 0; a_mcast = 0;
        checks++;
        if (a_ovalid !== 16'h8101 || a_dout[0 +: 16] !== 16'h5A5A ||
            a_dout[8*16 +: 16] !== 16'h5A5A || a_dout[15*16 +: 16] !== 16'h5A5A) begin
            errors++;
            $display("FAIL mc_load: o_valid=%h ch0=%h ch8=%h ch15=%h, required 8101 5a5a x3",
                     a_ovalid, a_dout[0 +: 16], a_dout[8*16 +: 16], a_dout[15*16 +: 16]);
        end
        a_iready = 16'h0101;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL mc_partial_ready: o_ready=%b, required 0", a_ready);
        end
        step();
        a_iready = 16'h0000;
        #1;
        checks++;
        if (a_ovalid !== 16'h8000 || a_ready !== 1'b0 || a_dout[0 +: 16] !== 16'h0000 ||
            a_dout[15*16 +: 16] !== 16'h5A5A) begin
            errors++;
            $display("FAIL mc_partial: o_valid=%h o_ready=%b ch0=%h ch15=%h, required 8000 0 0000 5a5a",
                     a_ovalid, a_ready, a_dout[0 +: 16], a_dout[15*16 +: 16]);
        end
        $display("[tb] multicast partial drain o_valid=%h", a_ovalid);
        step();
        checks++;
        if (a_ovalid !== 16'h8000) begin
            errors++;
            $display("FAIL mc_stall: o_valid=%h, required 8000", a_ovalid);
        end
        a_iready = 16'h8000;
        a_valid = 1; a_sel = 4'd2; a_din = 16'h7777;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mc_last_ready: o_ready=%b, required 1", a_ready);
        end
        step();
        a_valid = 0;
        a_iready = 16'hFFFF;
        checks++;
        if (a_ovalid !== 16'h0004 || a_dout[2*16 +: 16] !== 16'h7777) begin
            errors++;
            $display("FAIL mc_next_beat: o_valid=%h ch2=%h, required 0004 7777", a_ovalid, a_dout[2*16 +: 16]);
        end
        $display("[tb] multicast next beat o_valid=%h", a_ovalid);
        step();
        checks++;
        if (a_ovalid !== 16'h0000) begin
            errors++;
            $display("FAIL mc_done: o_valid=%h, required 0000", a_ovalid);
        end
    endtask

    task automatic test_drop();
        b_iready = '1;
        b_valid = 1; b_sel = 4'd13; b_mcast = 0; b_din = 16'hDEAD;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready: o_ready=%b, required 1", b_ready);
        end
        step();
        b_valid = 0;
        checks++;
        if (b_ovalid !== 12'h000 || b_drop !== 1'b1 || b_cnt !== 2'd1) begin
            errors++;
            $display("FAIL drop_sel13: o_valid=%h drop=%b cnt=%0d, required 000 1 1", b_ovalid, b_drop, b_cnt);
        end
        step();
        checks++;
        if (b_drop !== 1'b0 || b_cnt !== 2'd1) begin
            errors++;
            $display("FAIL drop_pulse: drop=%b cnt=%0d, required 0 1", b_drop, b_cnt);
        end
        b_valid = 1; b_mcast = 1; b_mask = 12'h000;
        step();
        b_valid = 0;
        checks++;
        if (b_drop !== 1'b1 || b_cnt !== 2'd2 || b_ovalid !== 12'h000) begin
            errors++;
            $display("FAIL drop_mask0: drop=%b cnt=%0d o_valid=%h, required 1 2 000", b_drop, b_cnt, b_ovalid);
        end
        b_mcast = 0; b_sel = 4'd13;
        for (int k = 0; k < 3; k++) begin
            b_valid = 1;
            step();
            checks++;
            if (b_cnt !== 2'd3 || b_drop !== 1'b1) begin
                errors++;
                $display("FAIL drop_sat[%0d]: cnt=%0d drop=%b, required 3 1", k, b_cnt, b_drop);
            end
            $display("[tb] drop %0d cnt=%0d", k + 3, b_cnt);
        end
        b_valid = 0;
        step();
        checks++;
        if (b_cnt !== 2'd3 || b_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_final: cnt=%0d drop=%b, required 3 0", b_cnt, b_drop);
        end
        // One multicast drop on the 16-way instance so its counter is nonzero before reset.
        a_valid = 1; a_mcast = 1; a_mask = 16'h0000;
        step();
        a_valid = 0; a_mcast = 0;
        checks++;
        if (a_cnt !== 8'd1 || a_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_a: cnt=%0d drop=%b, required 1 1", a_cnt, a_drop);
        end
    endtask

    task automatic test_reset_mid();
        a_iready = 16'h0000;
        a_valid = 1; a_mcast = 1; a_mask = 16'h00F0; a_din = 16'hBEEF;
        step();
        a_valid = 0; a_mcast = 0;
        checks++;
        if (a_ovalid !== 16'h00F0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL rm_pending: o_valid=%h o_ready=%b, required 00f0 0", a_ovalid, a_ready);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (a_ovalid !== 16'h0000 || a_dout !== '0 || a_cnt !== 8'd0 || b_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rm_async: o_valid=%h dout_nonzero=%0b cnt_a=%0d cnt_b=%0d, required 0000 0 0 0",
                     a_ovalid, |a_dout, a_cnt, b_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_ready: o_ready=%b, required 1", a_ready);
        end
        step();
        checks++;
        if (a_ovalid !== 16'h0000 || a_drop !== 1'b0) begin
            errors++;
            $display("FAIL rm_after: o_valid=%h drop=%b, required 0000 0", a_ovalid, a_drop);
        end
        $display("[tb] mid-operation reset done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unicast();
        test_back_to_back();
        test_backpressure();
        test_multicast();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
